// File: rtl/issue_queue.sv
// issue_queue: collapsing out-of-order issue queue placed after register rename.
//
// Entry 0 is always the oldest. Valid entries occupy indices 0..count-1. Each
// cycle the oldest entry whose sources are both ready is presented on out_*;
// when execute accepts it, the entry is removed and every younger entry
// shifts down by one slot on the same clock edge. Writeback broadcasts set
// the per-source ready bits of matching entries.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   flush            discard every entry (branch mispredict)
//   in_*             one renamed instruction per cycle (valid/ready handshake)
//   wb_valid, wb_phy writeback wakeup broadcast
//   out_*            oldest ready entry (valid/ready handshake), zero when idle
//   count            number of occupied entries
//
// Optional feature macro: ISSUE_QUEUE_WAKEUP_BYPASS_EN
//   defined   : a stored source also counts as ready during the cycle its
//               producer is broadcast (wb -> out_valid combinational path)
//   undefined : select looks only at the stored ready bits
module issue_queue #(
    parameter int DEPTH        = 8,
    parameter int PHY_REG_BITS = 6,
    parameter int ROB_TAG_BITS = 4,
    parameter int PAYLOAD_W    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PHY_REG_BITS-1:0]    in_rs_phy,
    input  logic                       in_rs_ready,
    input  logic [PHY_REG_BITS-1:0]    in_rt_phy,
    input  logic                       in_rt_ready,
    input  logic [PHY_REG_BITS-1:0]    in_rw_phy,
    input  logic                       in_uses_rw,
    input  logic [ROB_TAG_BITS-1:0]    in_rob_tag,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic                       wb_valid,
    input  logic [PHY_REG_BITS-1:0]    wb_phy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PHY_REG_BITS-1:0]    out_rs_phy,
    output logic [PHY_REG_BITS-1:0]    out_rt_phy,
    output logic [PHY_REG_BITS-1:0]    out_rw_phy,
    output logic                       out_uses_rw,
    output logic [ROB_TAG_BITS-1:0]    out_rob_tag,
    output logic [PAYLOAD_W-1:0]       out_payload,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic                    valid;
        logic [PHY_REG_BITS-1:0] rs_phy;
        logic                    rs_rdy;
        logic [PHY_REG_BITS-1:0] rt_phy;
        logic                    rt_rdy;
        logic [PHY_REG_BITS-1:0] rw_phy;
        logic                    uses_rw;
        logic [ROB_TAG_BITS-1:0] rob_tag;
        logic [PAYLOAD_W-1:0]    payload;
    } entry_t;

    entry_t          q      [DEPTH];
    entry_t          woken  [DEPTH];
    entry_t          q_next [DEPTH];
    entry_t          incoming;
    logic [DEPTH-1:0] ready;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic            iss;
    logic            enq;
    logic [CW-1:0]   wr_idx;
    logic [CW-1:0]   count_next;

    // Per-entry readiness used by select.
    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
            ready[i] = q[i].valid
                     && (q[i].rs_rdy || (wb_valid && q[i].rs_phy == wb_phy))
                     && (q[i].rt_rdy || (wb_valid && q[i].rt_phy == wb_phy));
`else
            ready[i] = q[i].valid && q[i].rs_rdy && q[i].rt_rdy;
`endif
        end
    end

    // Scan from the youngest slot down so the oldest ready entry wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (ready[i-1]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i - 1);
            end
        end
    end

    always_comb begin
        out_valid   = sel_found;
        out_rs_phy  = '0;
        out_rt_phy  = '0;
        out_rw_phy  = '0;
        out_uses_rw = 1'b0;
        out_rob_tag = '0;
        out_payload = '0;
        if (sel_found) begin
            out_rs_phy  = q[sel_idx].rs_phy;
            out_rt_phy  = q[sel_idx].rt_phy;
            out_rw_phy  = q[sel_idx].rw_phy;
            out_uses_rw = q[sel_idx].uses_rw;
            out_rob_tag = q[sel_idx].rob_tag;
            out_payload = q[sel_idx].payload;
        end
    end

    assign in_ready   = (count != CW'(DEPTH));
    assign iss        = sel_found && out_ready;
    assign enq        = in_valid && in_ready && !flush;
    // A same-cycle issue frees one slot below the current tail.
    assign wr_idx     = count - CW'(iss);
    assign count_next = count + CW'(enq) - CW'(iss);

    // Wakeup is applied before the collapse so a shifted entry keeps it.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woken[i] = q[i];
            if (q[i].valid && wb_valid) begin
                if (q[i].rs_phy == wb_phy) woken[i].rs_rdy = 1'b1;
                if (q[i].rt_phy == wb_phy) woken[i].rt_rdy = 1'b1;
            end
        end
    end

    // Incoming sources produced by this cycle's broadcast are stored ready.
    always_comb begin
        incoming.valid   = 1'b1;
        incoming.rs_phy  = in_rs_phy;
        incoming.rs_rdy  = in_rs_ready || (wb_valid && in_rs_phy == wb_phy);
        incoming.rt_phy  = in_rt_phy;
        incoming.rt_rdy  = in_rt_ready || (wb_valid && in_rt_phy == wb_phy);
        incoming.rw_phy  = in_rw_phy;
        incoming.uses_rw = in_uses_rw;
        incoming.rob_tag = in_rob_tag;
        incoming.payload = in_payload;
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (iss && IW'(i) >= sel_idx) begin
                if (i == DEPTH - 1) q_next[i] = '0;
                else                q_next[i] = woken[i+1];
            end else begin
                q_next[i] = woken[i];
            end
            if (enq && CW'(i) == wr_idx) q_next[i] = incoming;
        end
    end

    // Flush clears the same state as reset; outputs follow from empty storage.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            count <= count_next;
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= q_next[i];
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: self-checking bench for issue_queue (DEPTH=8).
// Table of per-cycle vectors plus hand-written sequences; issued instructions
// are checked against a scoreboard queue of expected tags.
module tb_issue_queue;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, in_valid, in_ready, in_rs_ready, in_rt_ready, in_uses_rw;
    logic [5:0]  in_rs_phy, in_rt_phy, in_rw_phy, wb_phy;
    logic [3:0]  in_rob_tag;
    logic [63:0] in_payload;
    logic        wb_valid, out_valid, out_ready, out_uses_rw;
    logic [5:0]  out_rs_phy, out_rt_phy, out_rw_phy;
    logic [3:0]  out_rob_tag;
    logic [63:0] out_payload;
    logic [3:0]  count;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(8), .PHY_REG_BITS(6), .ROB_TAG_BITS(4), .PAYLOAD_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_phy(in_rs_phy), .in_rs_ready(in_rs_ready),
        .in_rt_phy(in_rt_phy), .in_rt_ready(in_rt_ready),
        .in_rw_phy(in_rw_phy), .in_uses_rw(in_uses_rw),
        .in_rob_tag(in_rob_tag), .in_payload(in_payload),
        .wb_valid(wb_valid), .wb_phy(wb_phy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_phy(out_rs_phy), .out_rt_phy(out_rt_phy), .out_rw_phy(out_rw_phy),
        .out_uses_rw(out_uses_rw), .out_rob_tag(out_rob_tag), .out_payload(out_payload),
        .count(count)
    );

    typedef struct {
        logic       in_valid;
        logic [3:0] tag;
        logic [5:0] rs;
        logic       rs_rdy;
        logic [5:0] rt;
        logic       rt_rdy;
        logic       wb_valid;
        logic [5:0] wb_phy;
        logic       out_ready;
        logic       flush;
        logic       chk;
        logic [3:0] e_count;
        logic       e_in_ready;
        logic       e_ov;
        logic [3:0] e_tag;
    } vec_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [3:0]  sb_q [$];
    logic [5:0]  drv_rs [16];
    logic [5:0]  drv_rt [16];
    vec_t        tbl [14];

    function automatic logic [63:0] payload_of(logic [3:0] t);
        return {16{t}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [5:0] rw_of(logic [3:0] t);
        return {2'b10, t};
    endfunction

    function automatic vec_t V(logic iv, logic [3:0] tag, logic [5:0] rs, logic rsr,
                               logic [5:0] rt, logic rtr, logic wbv, logic [5:0] wbp,
                               logic ordy, logic fl);
        vec_t v;
        v.in_valid = iv;  v.tag = tag;   v.rs = rs;       v.rs_rdy = rsr;
        v.rt = rt;        v.rt_rdy = rtr; v.wb_valid = wbv; v.wb_phy = wbp;
        v.out_ready = ordy; v.flush = fl; v.chk = F;
        v.e_count = 4'd0; v.e_in_ready = F; v.e_ov = F; v.e_tag = 4'd0;
        return v;
    endfunction

    function automatic vec_t E(vec_t vi, logic [3:0] c, logic ir, logic ov, logic [3:0] t);
        vec_t v = vi;
        v.chk = T; v.e_count = c; v.e_in_ready = ir; v.e_ov = ov; v.e_tag = t;
        return v;
    endfunction

    function automatic vec_t I(logic ordy);
        return V(F, 4'd0, 6'd0, T, 6'd0, T, F, 6'd0, ordy, F);
    endfunction

    task automatic check(input string n, input string f, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h, expected %0h", n, f, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string n);
        logic [3:0] et;
        flush       = v.flush;
        in_valid    = v.in_valid;
        in_rob_tag  = v.tag;
        in_rs_phy   = v.rs;
        in_rs_ready = v.rs_rdy;
        in_rt_phy   = v.rt;
        in_rt_ready = v.rt_rdy;
        in_rw_phy   = rw_of(v.tag);
        in_uses_rw  = v.tag[0];
        in_payload  = payload_of(v.tag);
        wb_valid    = v.wb_valid;
        wb_phy      = v.wb_phy;
        out_ready   = v.out_ready;
        if (v.in_valid) begin
            drv_rs[v.tag] = v.rs;
            drv_rt[v.tag] = v.rt;
        end
        @(negedge clk);
        if (v.chk) begin
            check(n, "count", 64'(count), 64'(v.e_count));
            check(n, "in_ready", 64'(in_ready), 64'(v.e_in_ready));
            check(n, "out_valid", 64'(out_valid), 64'(v.e_ov));
            if (v.e_ov) begin
                check(n, "out_rob_tag", 64'(out_rob_tag), 64'(v.e_tag));
            end else begin
                check(n, "idle_tag", 64'(out_rob_tag), 64'd0);
                check(n, "idle_payload", out_payload, 64'd0);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s/issue: got tag %0d, expected no issue", n, out_rob_tag);
            end else begin
                et = sb_q.pop_front();
                check(n, "sb_tag", 64'(out_rob_tag), 64'(et));
                check(n, "sb_payload", out_payload, payload_of(et));
                check(n, "sb_rw", 64'(out_rw_phy), 64'(rw_of(et)));
                check(n, "sb_uses_rw", 64'(out_uses_rw), 64'(et[0]));
                check(n, "sb_rs", 64'(out_rs_phy), 64'(drv_rs[et]));
                check(n, "sb_rt", 64'(out_rt_phy), 64'(drv_rt[et]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // in-order stream: tags 1,2,3 all ready, execute always accepting
        tbl[0]  = E(V(T, 4'd1, 6'd1, T, 6'd2, T, F, 6'd0, T, F), 4'd0, T, F, 4'd0);
        tbl[1]  = E(V(T, 4'd2, 6'd1, T, 6'd2, T, F, 6'd0, T, F), 4'd1, T, T, 4'd1);
        tbl[2]  = E(V(T, 4'd3, 6'd1, T, 6'd2, T, F, 6'd0, T, F), 4'd1, T, T, 4'd2);
        tbl[3]  = E(I(T), 4'd1, T, T, 4'd3);
        tbl[4]  = E(I(T), 4'd0, T, F, 4'd0);
        // tag 5 waits on p40, younger tag 6 overtakes it
        tbl[5]  = E(V(T, 4'd5, 6'd40, F, 6'd2, T, F, 6'd0, T, F), 4'd0, T, F, 4'd0);
        tbl[6]  = E(V(T, 4'd6, 6'd1, T, 6'd2, T, F, 6'd0, T, F), 4'd1, T, F, 4'd0);
        tbl[7]  = E(I(T), 4'd2, T, T, 4'd6);
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
        tbl[8]  = E(V(F, 4'd0, 6'd0, T, 6'd0, T, T, 6'd40, T, F), 4'd1, T, T, 4'd5);
        tbl[9]  = E(I(T), 4'd0, T, F, 4'd0);
`else
        tbl[8]  = E(V(F, 4'd0, 6'd0, T, 6'd0, T, T, 6'd40, T, F), 4'd1, T, F, 4'd0);
        tbl[9]  = E(I(T), 4'd1, T, T, 4'd5);
`endif
        tbl[10] = E(I(T), 4'd0, T, F, 4'd0);
        // incoming source matched by same-cycle broadcast is stored ready
        tbl[11] = E(V(T, 4'd4, 6'd40, F, 6'd2, T, T, 6'd40, T, F), 4'd0, T, F, 4'd0);
        tbl[12] = E(I(T), 4'd1, T, T, 4'd4);
        tbl[13] = E(I(T), 4'd0, T, F, 4'd0);

        // reset
        rst_n = 1'b0;
        step(I(F), "rst0");
        step(I(F), "rst1");
        rst_n = 1'b1;
        step(E(I(F), 4'd0, T, F, 4'd0), "reset");

        for (int k = 0; k < 14; k++) begin
            if (tbl[k].chk && tbl[k].e_ov && tbl[k].out_ready) sb_q.push_back(tbl[k].e_tag);
            step(tbl[k], $sformatf("vec%0d", k));
        end

        // reset in the middle of operation
        step(E(V(T, 4'd7, 6'd1, T, 6'd2, T, F, 6'd0, F, F), 4'd0, T, F, 4'd0), "mrst_a");
        step(E(V(T, 4'd8, 6'd1, T, 6'd2, T, F, 6'd0, F, F), 4'd1, T, T, 4'd7), "mrst_b");
        rst_n = 1'b0;
        step(E(V(T, 4'd13, 6'd1, T, 6'd2, T, F, 6'd0, F, F), 4'd2, T, T, 4'd7), "mrst");
        rst_n = 1'b1;
        step(E(I(F), 4'd0, T, F, 4'd0), "mrst_after");
        step(E(I(T), 4'd0, T, F, 4'd0), "mrst_after2");

        // fill to DEPTH with unready entries, reject one, then wake and issue tag 3
        for (int k = 0; k < 8; k++)
            step(E(V(T, 4'(k), 6'(48 + k), F, 6'd2, T, F, 6'd0, T, F), 4'(k), T, F, 4'd0),
                 "full_fill");
        step(E(V(T, 4'd15, 6'd1, T, 6'd2, T, F, 6'd0, T, F), 4'd8, F, F, 4'd0), "full_reject");
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
        sb_q.push_back(4'd3);
        step(E(V(T, 4'd15, 6'd1, T, 6'd2, T, T, 6'd51, T, F), 4'd8, F, T, 4'd3), "full_wake");
`else
        step(E(V(T, 4'd15, 6'd1, T, 6'd2, T, T, 6'd51, T, F), 4'd8, F, F, 4'd0), "full_wake");
        sb_q.push_back(4'd3);
        step(E(V(T, 4'd15, 6'd1, T, 6'd2, T, F, 6'd0, T, F), 4'd8, F, T, 4'd3), "full_issue");
`endif
        step(E(I(T), 4'd7, T, F, 4'd0), "full_after");
        step(E(V(F, 4'd0, 6'd0, T, 6'd0, T, F, 6'd0, T, T), 4'd7, T, F, 4'd0), "flush7");
        step(E(I(T), 4'd0, T, F, 4'd0), "flush7_after");

        // flush with count=5 while a ready instruction is offered
        for (int k = 0; k < 5; k++)
            step(E(V(T, 4'(k), 6'(48 + k), F, 6'd2, T, F, 6'd0, T, F), 4'(k), T, F, 4'd0),
                 "flush5_fill");
        step(E(V(T, 4'd14, 6'd1, T, 6'd2, T, F, 6'd0, T, T), 4'd5, T, F, 4'd0), "flush5");
        step(E(I(T), 4'd0, T, F, 4'd0), "flush5_after");
        step(E(I(T), 4'd0, T, F, 4'd0), "flush5_after2");

        // issue middle entry while enqueuing tag 9 and waking entry 2's rt
        step(E(V(T, 4'd10, 6'd50, F, 6'd2, T, F, 6'd0, F, F), 4'd0, T, F, 4'd0), "sim_a");
        step(E(V(T, 4'd11, 6'd1, T, 6'd2, T, F, 6'd0, F, F), 4'd1, T, F, 4'd0), "sim_b");
        step(E(V(T, 4'd12, 6'd3, T, 6'd52, F, F, 6'd0, F, F), 4'd2, T, T, 4'd11), "sim_c");
        sb_q.push_back(4'd11);
        step(E(V(T, 4'd9, 6'd53, F, 6'd2, T, T, 6'd52, T, F), 4'd3, T, T, 4'd11), "sim_x");
        step(E(I(F), 4'd3, T, T, 4'd12), "sim_y");
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
        step(E(V(F, 4'd0, 6'd0, T, 6'd0, T, T, 6'd50, F, F), 4'd3, T, T, 4'd10), "sim_w50");
`else
        step(E(V(F, 4'd0, 6'd0, T, 6'd0, T, T, 6'd50, F, F), 4'd3, T, T, 4'd12), "sim_w50");
`endif
        step(E(I(F), 4'd3, T, T, 4'd10), "sim_old");
        sb_q.push_back(4'd10);
        step(E(V(F, 4'd0, 6'd0, T, 6'd0, T, T, 6'd53, T, F), 4'd3, T, T, 4'd10), "sim_i10");
        sb_q.push_back(4'd12);
        step(E(I(T), 4'd2, T, T, 4'd12), "sim_i12");
        sb_q.push_back(4'd9);
        step(E(I(T), 4'd1, T, T, 4'd9), "sim_i9");
        step(E(I(T), 4'd0, T, F, 4'd0), "sim_end");

        check("end", "sb_outstanding", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
